// File: rtl/sprite_renderer_ext.sv
// sprite_renderer_ext: renders flipped/clipped sprite rows from DDR into the inactive frame buffer via MIG ports
module sprite_renderer_ext #(
    parameter int Width = 640,
    parameter int Height = 480,
    parameter int FrameBufferZeroStartAddress = 0,
    parameter int FrameBufferOneStartAddress = 614400,
    parameter int SpritePixelDataStartAddress = 1228800,
    parameter int SpriteWidthLog2 = 5,
    parameter int SpriteHeightLog2 = 5,
    parameter logic [15:0] TransparentPixelColour = 16'hD11C
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        calib_done,
    input  logic        RenderNextFrame,
    output logic        FinishedRendering,
    input  logic [11:0] NumSprites,
    output logic [11:0] SpriteInfoAddress,
    input  logic [31:0] SpriteInfoData,
    input  logic        FrameBufferActive,
    output logic        write_cmd_clk,
    output logic        write_cmd_en,
    output logic [2:0]  write_cmd_instr,
    output logic [5:0]  write_cmd_bl,
    output logic [29:0] write_cmd_byte_addr,
    input  logic        write_cmd_full,
    output logic        wr_clk,
    output logic        wr_en,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    input  logic [6:0]  wr_count,
    output logic        read_cmd_clk,
    output logic        read_cmd_en,
    output logic [2:0]  read_cmd_instr,
    output logic [5:0]  read_cmd_bl,
    output logic [29:0] read_cmd_byte_addr,
    input  logic        read_cmd_full,
    output logic        rd_clk,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty
);
    localparam int SH = SpriteHeightLog2;
    localparam int W = 2 ** (SpriteWidthLog2 - 1);
    localparam int KB = SpriteWidthLog2 > 1 ? SpriteWidthLog2 - 1 : 1;
    localparam logic [KB-1:0] KLAST = KB'(W - 1);
    localparam logic [SH:0] RLAST = (SH + 1)'(2 ** SH);
    localparam logic [11:0] W12 = 12'(Width);
    localparam logic [11:0] H12 = 12'(Height);
    localparam logic [29:0] W30 = 30'(Width);
    localparam logic [29:0] FB0 = 30'(FrameBufferZeroStartAddress);
    localparam logic [29:0] FB1 = 30'(FrameBufferOneStartAddress);
    localparam logic [29:0] SPA = 30'(SpritePixelDataStartAddress);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ROW_CHECK, READ_CMD, LOAD, WRITE_DATA, WRITE_CMD, WRITE_DRAIN
    } state_t;

    state_t state;
    logic [11:0] sprite_cnt;
    logic fb_sel, flip_x, flip_y;
    logic [9:0] xpos;
    logic [8:0] ypos;
    logic [29:0] img_base;
    logic [SH:0] r;
    logic [KB-1:0] k;
    logic [31:0] lbuf [2**KB];
    logic [11:0] row_y, px;
    logic [SH-1:0] src_row;
    logic [KB-1:0] buf_idx;
    logic [31:0] word;
    logic in_wd;

    assign write_cmd_clk = Clk;
    assign wr_clk = Clk;
    assign read_cmd_clk = Clk;
    assign rd_clk = Clk;
    assign write_cmd_instr = 3'b000;
    assign read_cmd_instr = 3'b001;
    assign write_cmd_bl = 6'(W - 1);
    assign read_cmd_bl = 6'(W - 1);
    assign SpriteInfoAddress = sprite_cnt;

    always_comb begin
        row_y = 12'(ypos) + 12'(r);
        src_row = flip_y ? ~r[SH-1:0] : r[SH-1:0];
        buf_idx = flip_x ? KLAST - k : k;
        word = flip_x ? {lbuf[buf_idx][15:0], lbuf[buf_idx][31:16]} : lbuf[buf_idx];
        px = 12'(xpos) + 12'({k, 1'b0});
        in_wd = state == WRITE_DATA;
        wr_en = in_wd && !wr_full;
        rd_en = state == LOAD && !rd_empty;
        read_cmd_en = state == READ_CMD && !read_cmd_full;
        write_cmd_en = state == WRITE_CMD && !write_cmd_full;
        wr_data = in_wd ? word : 32'd0;
        wr_mask = in_wd ? {{2{word[31:16] == TransparentPixelColour || px + 12'd1 >= W12}},
                           {2{word[15:0] == TransparentPixelColour || px >= W12}}} : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Rst || !calib_done) begin
            state <= IDLE;
            sprite_cnt <= '0;
            fb_sel <= 1'b0;
            flip_x <= 1'b0;
            flip_y <= 1'b0;
            xpos <= '0;
            ypos <= '0;
            img_base <= '0;
            r <= '0;
            k <= '0;
            FinishedRendering <= 1'b0;
            read_cmd_byte_addr <= '0;
            write_cmd_byte_addr <= '0;
        end else begin
            FinishedRendering <= 1'b0;
            case (state)
                IDLE: begin
                    sprite_cnt <= '0;
                    if (RenderNextFrame) begin
                        fb_sel <= FrameBufferActive;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    FinishedRendering <= sprite_cnt >= NumSprites;
                    state <= sprite_cnt >= NumSprites ? IDLE : DECODE;
                end
                DECODE: begin
                    xpos <= SpriteInfoData[9:0];
                    ypos <= SpriteInfoData[18:10];
                    flip_x <= SpriteInfoData[30];
                    flip_y <= SpriteInfoData[31];
                    r <= '0;
                    img_base <= SPA + (30'(SpriteInfoData[28:19]) << (SpriteWidthLog2 + SH + 1));
                    if (!SpriteInfoData[29] || 12'(SpriteInfoData[9:0]) >= W12 || 12'(SpriteInfoData[18:10]) >= H12) begin
                        sprite_cnt <= sprite_cnt + 12'd1;
                        state <= FETCH;
                    end else begin
                        state <= ROW_CHECK;
                    end
                end
                ROW_CHECK: begin
                    if (r == RLAST || row_y >= H12) begin
                        sprite_cnt <= sprite_cnt + 12'd1;
                        state <= FETCH;
                    end else begin
                        read_cmd_byte_addr <= img_base + (30'(src_row) << (SpriteWidthLog2 + 1));
                        write_cmd_byte_addr <= (fb_sel ? FB0 : FB1) + ((30'(row_y) * W30 + 30'(xpos)) << 1);
                        state <= READ_CMD;
                    end
                end
                READ_CMD: begin
                    k <= '0;
                    if (!read_cmd_full) state <= LOAD;
                end
                LOAD: begin
                    if (!rd_empty) begin
                        k <= k == KLAST ? '0 : k + KB'(1);
                        if (k == KLAST) state <= WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (!wr_full) begin
                        k <= k == KLAST ? '0 : k + KB'(1);
                        if (k == KLAST) state <= WRITE_CMD;
                    end
                end
                WRITE_CMD: if (!write_cmd_full) state <= WRITE_DRAIN;
                WRITE_DRAIN: begin
                    if (wr_count == 7'd0) begin
                        r <= r + (SH + 1)'(1);
                        state <= ROW_CHECK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (state == LOAD && !rd_empty) lbuf[k] <= rd_data;
    end
endmodule

// File: tb/tb_sprite_renderer_ext.sv
// tb_sprite_renderer_ext: directed checks of sprite_renderer_ext against a small MIG/BRAM model
module tb_sprite_renderer_ext;
    logic Clk = 0, Rst = 1, calib_done = 1, RenderNextFrame = 0, FinishedRendering;
    logic [11:0] NumSprites = 0, SpriteInfoAddress;
    logic [31:0] SpriteInfoData = 0;
    logic FrameBufferActive = 0;
    logic write_cmd_clk, write_cmd_en, wr_clk, wr_en, read_cmd_clk, read_cmd_en, rd_clk, rd_en;
    logic [2:0] write_cmd_instr, read_cmd_instr;
    logic [5:0] write_cmd_bl, read_cmd_bl;
    logic [29:0] write_cmd_byte_addr, read_cmd_byte_addr;
    logic write_cmd_full = 0, read_cmd_full = 0, wr_full = 0, rd_empty = 1;
    logic [3:0] wr_mask;
    logic [31:0] wr_data, rd_data = 0;
    logic [6:0] wr_count = 0;

    sprite_renderer_ext dut (
        .Clk(Clk), .Rst(Rst), .calib_done(calib_done), .RenderNextFrame(RenderNextFrame),
        .FinishedRendering(FinishedRendering), .NumSprites(NumSprites),
        .SpriteInfoAddress(SpriteInfoAddress), .SpriteInfoData(SpriteInfoData),
        .FrameBufferActive(FrameBufferActive), .write_cmd_clk(write_cmd_clk),
        .write_cmd_en(write_cmd_en), .write_cmd_instr(write_cmd_instr), .write_cmd_bl(write_cmd_bl),
        .write_cmd_byte_addr(write_cmd_byte_addr), .write_cmd_full(write_cmd_full),
        .wr_clk(wr_clk), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
        .wr_count(wr_count), .read_cmd_clk(read_cmd_clk), .read_cmd_en(read_cmd_en),
        .read_cmd_instr(read_cmd_instr), .read_cmd_bl(read_cmd_bl),
        .read_cmd_byte_addr(read_cmd_byte_addr), .read_cmd_full(read_cmd_full),
        .rd_clk(rd_clk), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 Clk = ~Clk;

    logic [31:0] info [4];
    logic key_mode = 0;
    logic [29:0] rcmd_q[$], wcmd_q[$];
    logic [31:0] wdat_q[$], rdq[$];
    logic [3:0] wmask_q[$];
    int rrow_q[$], wrow_q[$];
    int done_cnt = 0, viol = 0, rd_cnt = 0, wr_cnt = 0;
    int checks = 0, errors = 0;

    always @(posedge Clk) SpriteInfoData <= info[SpriteInfoAddress[1:0]];

    function automatic logic [31:0] pat(input logic [29:0] a, input int j);
        logic [29:0] s;
        s = a >> 6;
        return (key_mode && j == 0) ? 32'h1234_D11C : {s[7:0], 8'(j), 8'h55, 8'(j)};
    endfunction

    function automatic logic [31:0] sp(input int x, input int y, input int img, input logic vis, input logic fx, input logic fy);
        return {fy, fx, vis, 10'(img), 9'(y), 10'(x)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Observe DUT strobes at negedge, update the read FIFO just after the following posedge
    initial begin
        logic do_pop, do_push;
        logic [29:0] a;
        forever begin
            @(negedge Clk);
            do_pop = rd_en;
            do_push = read_cmd_en;
            a = read_cmd_byte_addr;
            if (read_cmd_en) rcmd_q.push_back(read_cmd_byte_addr);
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                wdat_q.push_back(wr_data);
                wmask_q.push_back(wr_mask);
                wr_cnt++;
            end
            if (write_cmd_en) begin
                wcmd_q.push_back(write_cmd_byte_addr);
                rrow_q.push_back(rd_cnt);
                wrow_q.push_back(wr_cnt);
                rd_cnt = 0;
                wr_cnt = 0;
            end
            if (FinishedRendering) done_cnt++;
            if ((write_cmd_en && write_cmd_full) || (read_cmd_en && read_cmd_full) ||
                (rd_en && rd_empty) || (wr_en && wr_full)) viol++;
            @(posedge Clk);
            #1;
            if (Rst) begin
                rdq.delete();
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (do_pop && rdq.size() > 0) void'(rdq.pop_front());
                if (do_push) for (int j = 0; j < 16; j++) rdq.push_back(pat(a, j));
            end
            rd_empty = rdq.size() == 0;
            rd_data = rd_empty ? 32'd0 : rdq[0];
        end
    end

    task automatic clr();
        rcmd_q.delete(); wcmd_q.delete(); wdat_q.delete(); wmask_q.delete();
        rrow_q.delete(); wrow_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input int n, input logic fba);
        @(posedge Clk); #1;
        NumSprites = 12'(n);
        FrameBufferActive = fba;
        RenderNextFrame = 1;
        @(posedge Clk); #1;
        RenderNextFrame = 0;
    endtask

    task automatic finish_frame(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(negedge Clk); #1;
        end
        repeat (4) @(negedge Clk);
        #1;
        chk("frame_done", done_cnt, 1);
    endtask

    task automatic run(input int n, input logic fba);
        clr();
        start_frame(n, fba);
        finish_frame(6000 * n);
    endtask

    task automatic row_counts(input string tag);
        int bad = 0;
        foreach (rrow_q[i]) if (rrow_q[i] != 16 || wrow_q[i] != 16) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_done", FinishedRendering, 0);
        chk("rst_strobes", {read_cmd_en, write_cmd_en, rd_en, wr_en}, 0);
        chk("rst_addr", SpriteInfoAddress, 0);
        chk("rst_raddr", read_cmd_byte_addr, 0);
        chk("rst_waddr", write_cmd_byte_addr, 0);
        chk("rst_wdata", {wr_mask, wr_data[27:0]}, 0);
        chk("instr", {write_cmd_instr, read_cmd_instr}, 6'b000001);
        chk("bl", {write_cmd_bl, read_cmd_bl}, {6'd15, 6'd15});
        Rst = 0;
        repeat (2) @(posedge Clk);

        clr();
        start_frame(0, 1);
        @(negedge Clk); chk("empty_c1", FinishedRendering, 0);
        @(negedge Clk); chk("empty_c2", FinishedRendering, 1);
        @(negedge Clk); chk("empty_c3", FinishedRendering, 0);

        info[0] = sp(10, 20, 3, 1, 0, 0);
        run(1, 1);
        chk("t1_nrd", rcmd_q.size(), 32);
        chk("t1_nwr", wcmd_q.size(), 32);
        chk("t1_rd0", rcmd_q[0], 1234944);
        chk("t1_rd31", rcmd_q[31], 1236928);
        chk("t1_wr0", wcmd_q[0], 25620);
        chk("t1_wr31", wcmd_q[31], 65300);
        chk("t1_d0", wdat_q[0], 32'h6000_5500);
        chk("t1_d17", wdat_q[17], 32'h6101_5501);
        chk("t1_m0", wmask_q[0], 0);
        row_counts("t1_rows");

        key_mode = 1;
        run(1, 0);
        key_mode = 0;
        chk("key_wr0", wcmd_q[0], 640020);
        chk("key_d0", wdat_q[0], 32'h1234_D11C);
        chk("key_m0", wmask_q[0], 4'b0011);
        chk("key_m1", wmask_q[1], 4'b0000);

        info[0] = sp(10, 20, 3, 1, 1, 1);
        run(1, 1);
        chk("flip_rd0", rcmd_q[0], 1236928);
        chk("flip_rd1", rcmd_q[1], 1236864);
        chk("flip_d0", wdat_q[0], 32'h550F_7F0F);
        chk("flip_d15", wdat_q[15], 32'h5500_7F00);
        chk("flip_d16", wdat_q[16], 32'h550F_7E0F);

        info[0] = sp(630, 20, 3, 1, 0, 0);
        run(1, 1);
        chk("xclip_wr0", wcmd_q[0], 26860);
        chk("xclip_m4", wmask_q[4], 4'b0000);
        chk("xclip_m5", wmask_q[5], 4'b1111);
        chk("xclip_m15", wmask_q[15], 4'b1111);
        row_counts("xclip_rows");

        info[0] = sp(10, 470, 3, 1, 0, 0);
        run(1, 1);
        chk("yclip_nrd", rcmd_q.size(), 10);
        chk("yclip_nwr", wcmd_q.size(), 10);
        chk("yclip_wr9", wcmd_q[9], 613140);

        info[0] = sp(8, 2, 1, 1, 0, 0);
        info[1] = sp(50, 50, 2, 0, 0, 0);
        info[2] = sp(100, 200, 4, 1, 0, 0);
        clr();
        write_cmd_full = 1;
        start_frame(3, 1);
        for (int i = 0; i < 2000 && wdat_q.size() < 16; i++) begin
            @(negedge Clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk); #1;
            chk("hold_en", write_cmd_en, 0);
            chk("hold_addr", write_cmd_byte_addr, 2576);
        end
        @(posedge Clk); #1;
        write_cmd_full = 0;
        @(negedge Clk); #1;
        chk("hold_release", write_cmd_en, 1);
        finish_frame(18000);
        chk("multi_nrd", rcmd_q.size(), 64);
        chk("multi_nwr", wcmd_q.size(), 64);
        chk("multi_rd0", rcmd_q[0], 1230848);
        chk("multi_rd32", rcmd_q[32], 1236992);
        chk("multi_wr0", wcmd_q[0], 2576);
        chk("multi_wr32", wcmd_q[32], 256200);
        row_counts("multi_rows");

        info[0] = sp(0, 0, 5, 1, 0, 0);
        info[1] = sp(0, 0, 7, 1, 0, 0);
        clr();
        start_frame(2, 1);
        for (int i = 0; i < 6000 && !(rcmd_q.size() >= 33 && rd_en); i++) begin
            @(negedge Clk); #1;
        end
        chk("abort_reached", rcmd_q.size(), 33);
        Rst = 1;
        @(posedge Clk); #2;
        chk("abort_strobes", {read_cmd_en, write_cmd_en, rd_en, wr_en}, 0);
        chk("abort_addr", SpriteInfoAddress, 0);
        @(posedge Clk); #1;
        Rst = 0;
        repeat (6) @(negedge Clk);
        #1;
        chk("abort_nodone", done_cnt, 0);
        run(2, 1);
        chk("restart_rd0", rcmd_q[0], 1239040);
        chk("restart_rd32", rcmd_q[32], 1243136);
        chk("handshake_viol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
